// File: rtl/param_reg_bank.sv
// Parameterised register bank: two combinational read ports, one write port,
// a pending bit per register, and a sequenced bank-clear state machine.
module param_reg_bank #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned ADDR_W   = 4,
    parameter bit          ZERO_REG = 1'b0,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              write,
    input  logic [ADDR_W-1:0] wrAddr,
    input  logic [DATA_W-1:0] wrData,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] rdAddrA,
    input  logic [ADDR_W-1:0] rdAddrB,
    output logic [DATA_W-1:0] rdDataA,
    output logic [DATA_W-1:0] rdDataB,
    output logic              busyA,
    output logic              busyB,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsvAddr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {StIdle, StClear, StDone} state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];
    logic [DEPTH-1:0]  pend_q, pend_d;
    logic              wr_acc;

    assign wr_ready = (state_q == StIdle);
    assign clr_busy = (state_q == StClear);
    assign clr_done = (state_q == StDone);
    assign wr_acc   = write & wr_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        regs_d  = regs_q;
        pend_d  = pend_q;
        unique case (state_q)
            StIdle: begin
                if (wr_acc) begin
                    regs_d[wrAddr] = wrData;
                    pend_d[wrAddr] = 1'b0;
                end
                // Applied after the write so a same-cycle reservation wins.
                if (rsv) begin
                    pend_d[rsvAddr] = 1'b1;
                end
                if (clr_req) begin
                    pend_d  = '0;
                    cnt_d   = '0;
                    state_d = StClear;
                end
            end
            StClear: begin
                regs_d[cnt_q] = '0;
                if (cnt_q == LAST_ADDR) begin
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + ADDR_W'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
        if (ZERO_REG) begin
            regs_d[0] = '0;
            pend_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            pend_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            regs_q  <= regs_d;
        end
    end

    always_comb begin
        rdDataA = regs_q[rdAddrA];
        if (BYPASS && wr_acc && (wrAddr == rdAddrA)) begin
            rdDataA = wrData;
        end
        if (ZERO_REG && (rdAddrA == '0)) begin
            rdDataA = '0;
        end
    end

    always_comb begin
        rdDataB = regs_q[rdAddrB];
        if (BYPASS && wr_acc && (wrAddr == rdAddrB)) begin
            rdDataB = wrData;
        end
        if (ZERO_REG && (rdAddrB == '0)) begin
            rdDataB = '0;
        end
    end

    assign busyA = pend_q[rdAddrA] & ~(ZERO_REG && (rdAddrA == '0));
    assign busyB = pend_q[rdAddrB] & ~(ZERO_REG && (rdAddrB == '0));

endmodule

// File: tb/tb_param_reg_bank.sv
// Directed bench for param_reg_bank: default, no-bypass, zero-register and
// wide (32x32) configurations side by side.
module tb_param_reg_bank;

    logic clk = 1'b0;
    logic rst_n = 1'b1;

    // Shared stimulus for the three 16x16 instances.
    logic        write;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic [3:0]  rd_addr_a, rd_addr_b;
    logic        rsv;
    logic [3:0]  rsv_addr;
    logic        clr_req;

    logic        wr_ready [3];
    logic [15:0] rd_a [3];
    logic [15:0] rd_b [3];
    logic        busy_a [3];
    logic        busy_b [3];
    logic        cbusy [3];
    logic        cdone [3];

    // Wide instance.
    logic        w_write;
    logic [4:0]  w_addr;
    logic [31:0] w_data;
    logic [4:0]  w_rda, w_rdb;
    logic        w_rsv;
    logic [4:0]  w_rsv_addr;
    logic        w_clr;
    logic        w_ready, w_busy_a, w_busy_b, w_cbusy, w_cdone;
    logic [31:0] w_rd_a, w_rd_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    param_reg_bank u_dflt (
        .clk(clk), .rst_n(rst_n), .write(write), .wrAddr(wr_addr), .wrData(wr_data),
        .wr_ready(wr_ready[0]), .rdAddrA(rd_addr_a), .rdAddrB(rd_addr_b),
        .rdDataA(rd_a[0]), .rdDataB(rd_b[0]), .busyA(busy_a[0]), .busyB(busy_b[0]),
        .rsv(rsv), .rsvAddr(rsv_addr), .clr_req(clr_req),
        .clr_busy(cbusy[0]), .clr_done(cdone[0])
    );

    param_reg_bank #(.BYPASS(1'b0)) u_nobyp (
        .clk(clk), .rst_n(rst_n), .write(write), .wrAddr(wr_addr), .wrData(wr_data),
        .wr_ready(wr_ready[1]), .rdAddrA(rd_addr_a), .rdAddrB(rd_addr_b),
        .rdDataA(rd_a[1]), .rdDataB(rd_b[1]), .busyA(busy_a[1]), .busyB(busy_b[1]),
        .rsv(rsv), .rsvAddr(rsv_addr), .clr_req(clr_req),
        .clr_busy(cbusy[1]), .clr_done(cdone[1])
    );

    param_reg_bank #(.ZERO_REG(1'b1)) u_zero (
        .clk(clk), .rst_n(rst_n), .write(write), .wrAddr(wr_addr), .wrData(wr_data),
        .wr_ready(wr_ready[2]), .rdAddrA(rd_addr_a), .rdAddrB(rd_addr_b),
        .rdDataA(rd_a[2]), .rdDataB(rd_b[2]), .busyA(busy_a[2]), .busyB(busy_b[2]),
        .rsv(rsv), .rsvAddr(rsv_addr), .clr_req(clr_req),
        .clr_busy(cbusy[2]), .clr_done(cdone[2])
    );

    param_reg_bank #(.DATA_W(32), .ADDR_W(5)) u_wide (
        .clk(clk), .rst_n(rst_n), .write(w_write), .wrAddr(w_addr), .wrData(w_data),
        .wr_ready(w_ready), .rdAddrA(w_rda), .rdAddrB(w_rdb),
        .rdDataA(w_rd_a), .rdDataB(w_rd_b), .busyA(w_busy_a), .busyB(w_busy_b),
        .rsv(w_rsv), .rsvAddr(w_rsv_addr), .clr_req(w_clr),
        .clr_busy(w_cbusy), .clr_done(w_cdone)
    );

    task automatic idle_inputs();
        write = 1'b0;  wr_addr = '0;  wr_data = '0;
        rsv = 1'b0;    rsv_addr = '0; clr_req = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rd_addr_a = 4'd5; rd_addr_b = 4'd9;
        w_write = 1'b0; w_addr = '0; w_data = '0; w_rda = '0; w_rdb = '0;
        w_rsv = 1'b0; w_rsv_addr = '0; w_clr = 1'b0;
        #1 rst_n = 1'b0;
        #2;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (wr_ready[k] !== 1'b1) begin
                failures++; $display("FAIL reset_wr_ready inst=%0d got=%b exp=1", k, wr_ready[k]);
            end
            checks++;
            if (cbusy[k] !== 1'b0 || cdone[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_clr inst=%0d got busy=%b done=%b exp 0/0", k, cbusy[k], cdone[k]);
            end
            checks++;
            if (rd_a[k] !== 16'h0 || rd_b[k] !== 16'h0 || busy_a[k] !== 1'b0 || busy_b[k] !== 1'b0) begin
                failures++;
                $display("FAIL reset_read inst=%0d got a=%h b=%h ba=%b bb=%b exp zeros",
                         k, rd_a[k], rd_b[k], busy_a[k], busy_b[k]);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_bypass();
        @(negedge clk);
        write = 1'b1; wr_addr = 4'd5; wr_data = 16'hBEEF; rd_addr_a = 4'd5; rd_addr_b = 4'd5;
        #1;
        checks++;
        if (rd_a[0] !== 16'hBEEF) begin
            failures++; $display("FAIL bypass_same_cycle got=%h exp=BEEF", rd_a[0]);
        end
        checks++;
        if (rd_b[0] !== 16'hBEEF) begin
            failures++; $display("FAIL bypass_port_b got=%h exp=BEEF", rd_b[0]);
        end
        checks++;
        if (rd_a[1] !== 16'h0) begin
            failures++; $display("FAIL nobypass_old_value got=%h exp=0000", rd_a[1]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_a[0] !== 16'hBEEF || rd_a[1] !== 16'hBEEF) begin
            failures++;
            $display("FAIL write_after_edge got dflt=%h nobyp=%h exp=BEEF", rd_a[0], rd_a[1]);
        end
    endtask

    task automatic test_reserve();
        @(negedge clk);
        rsv = 1'b1; rsv_addr = 4'd3; rd_addr_a = 4'd3; rd_addr_b = 4'd4;
        #1;
        checks++;
        if (busy_a[0] !== 1'b0) begin
            failures++; $display("FAIL busy_before_rsv_edge got=%b exp=0", busy_a[0]);
        end
        @(negedge clk);
        rsv = 1'b0;
        #1;
        checks++;
        if (busy_a[0] !== 1'b1 || busy_b[0] !== 1'b0) begin
            failures++; $display("FAIL busy_after_rsv got a=%b b=%b exp a=1 b=0", busy_a[0], busy_b[0]);
        end
        @(negedge clk);
        write = 1'b1; wr_addr = 4'd3; wr_data = 16'h0033;
        #1;
        checks++;
        if (busy_a[0] !== 1'b1 || rd_a[0] !== 16'h0033) begin
            failures++;
            $display("FAIL busy_held_under_bypass got busy=%b data=%h exp busy=1 data=0033",
                     busy_a[0], rd_a[0]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (busy_a[0] !== 1'b0) begin
            failures++; $display("FAIL busy_cleared_by_write got=%b exp=0", busy_a[0]);
        end
        @(negedge clk);
        write = 1'b1; wr_addr = 4'd3; wr_data = 16'h3333; rsv = 1'b1; rsv_addr = 4'd3;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (busy_a[0] !== 1'b1 || rd_a[0] !== 16'h3333) begin
            failures++;
            $display("FAIL rsv_write_same_cycle got busy=%b data=%h exp busy=1 data=3333",
                     busy_a[0], rd_a[0]);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge clk);
        write = 1'b1; wr_addr = 4'd0; wr_data = 16'h1234; rsv = 1'b1; rsv_addr = 4'd0;
        rd_addr_a = 4'd0;
        #1;
        checks++;
        if (rd_a[2] !== 16'h0 || rd_a[0] !== 16'h1234) begin
            failures++;
            $display("FAIL zero_reg_bypass got zero=%h dflt=%h exp zero=0000 dflt=1234",
                     rd_a[2], rd_a[0]);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (rd_a[2] !== 16'h0 || busy_a[2] !== 1'b0) begin
            failures++;
            $display("FAIL zero_reg_stored got data=%h busy=%b exp 0000/0", rd_a[2], busy_a[2]);
        end
        checks++;
        if (rd_a[0] !== 16'h1234 || busy_a[0] !== 1'b1) begin
            failures++;
            $display("FAIL reg0_normal got data=%h busy=%b exp 1234/1", rd_a[0], busy_a[0]);
        end
    endtask

    task automatic test_clear();
        int nb = 0;
        int nd = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            write = 1'b1; wr_addr = 4'(i); wr_data = 16'hA000 | 16'(i);
            rsv = 1'b1; rsv_addr = 4'(i);
        end
        @(negedge clk);
        idle_inputs();
        rd_addr_b = 4'd9;
        #1;
        checks++;
        if (rd_b[0] !== 16'hA009 || busy_b[0] !== 1'b1) begin
            failures++; $display("FAIL fill_readback got data=%h busy=%b exp A009/1", rd_b[0], busy_b[0]);
        end
        // Trigger the clear together with a write; the clear must win.
        @(negedge clk);
        write = 1'b1; wr_addr = 4'd9; wr_data = 16'h5555; clr_req = 1'b1;
        rd_addr_a = 4'd0; rd_addr_b = 4'd15;
        for (int c = 0; c < 24; c++) begin
            @(negedge clk);
            if (c == 0) begin
                write = 1'b1; wr_addr = 4'd2; wr_data = 16'hFFFF;
                rsv = 1'b1; rsv_addr = 4'd4; clr_req = 1'b1;
            end
            #1;
            if (cbusy[0]) begin
                nb++;
                if (nb == 1) begin
                    checks++;
                    if (wr_ready[0] !== 1'b0) begin
                        failures++; $display("FAIL wr_ready_in_clear got=%b exp=0", wr_ready[0]);
                    end
                end
                if (nb == 2) begin
                    checks++;
                    if (rd_a[0] !== 16'h0 || rd_b[0] !== 16'hA00F) begin
                        failures++;
                        $display("FAIL read_mid_clear got a0=%h a15=%h exp 0000/A00F", rd_a[0], rd_b[0]);
                    end
                end
            end
            if (cdone[0]) begin
                nd++;
                checks++;
                if (cbusy[0] !== 1'b0) begin
                    failures++; $display("FAIL busy_during_done got=%b exp=0", cbusy[0]);
                end
            end
            if (!cbusy[0]) idle_inputs();
        end
        checks++;
        if (nb != 16) begin
            failures++; $display("FAIL clear_length got=%0d exp=16", nb);
        end
        checks++;
        if (nd != 1) begin
            failures++; $display("FAIL clear_done_pulses got=%0d exp=1", nd);
        end
        for (int a = 0; a < 16; a++) begin
            rd_addr_a = 4'(a);
            #1;
            checks++;
            if (rd_a[0] !== 16'h0 || busy_a[0] !== 1'b0) begin
                failures++;
                $display("FAIL post_clear addr=%0d got data=%h busy=%b exp 0000/0", a, rd_a[0], busy_a[0]);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int nb = 0;
        int nd = 0;
        @(negedge clk);
        write = 1'b1; wr_addr = 4'd10; wr_data = 16'h1111;
        @(negedge clk);
        idle_inputs();
        clr_req = 1'b1; rd_addr_a = 4'd10;
        @(negedge clk);
        clr_req = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (cbusy[0] !== 1'b1 || rd_a[0] !== 16'h1111) begin
            failures++;
            $display("FAIL pre_abort_state got busy=%b data=%h exp 1/1111", cbusy[0], rd_a[0]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (wr_ready[0] !== 1'b1 || cbusy[0] !== 1'b0 || cdone[0] !== 1'b0 || rd_a[0] !== 16'h0) begin
            failures++;
            $display("FAIL async_abort got ready=%b busy=%b done=%b data=%h exp 1/0/0/0000",
                     wr_ready[0], cbusy[0], cdone[0], rd_a[0]);
        end
        @(negedge clk);
        rst_n = 1'b1;
        write = 1'b1; wr_addr = 4'd4; wr_data = 16'h4444; rd_addr_a = 4'd4;
        #1;
        checks++;
        if (wr_ready[0] !== 1'b1 || rd_a[0] !== 16'h4444) begin
            failures++;
            $display("FAIL first_write_after_reset got ready=%b data=%h exp 1/4444", wr_ready[0], rd_a[0]);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            if (cdone[0]) nd++;
            if (cbusy[0]) nb++;
        end
        checks++;
        if (nd != 0 || nb != 0) begin
            failures++; $display("FAIL no_done_after_abort got done=%0d busy=%0d exp 0/0", nd, nb);
        end
        checks++;
        if (rd_a[0] !== 16'h4444) begin
            failures++; $display("FAIL write_after_reset_stored got=%h exp=4444", rd_a[0]);
        end
    endtask

    task automatic test_wide();
        int nb = 0;
        int nd = 0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            w_write = 1'b1; w_addr = 5'(i); w_data = 32'hFFFF_FFFF;
        end
        @(negedge clk);
        w_write = 1'b0; w_rda = 5'd31; w_rdb = 5'd17;
        #1;
        checks++;
        if (w_rd_a !== 32'hFFFF_FFFF || w_rd_b !== 32'hFFFF_FFFF) begin
            failures++; $display("FAIL wide_fill got a=%h b=%h exp FFFFFFFF", w_rd_a, w_rd_b);
        end
        w_clr = 1'b1;
        for (int c = 0; c < 48; c++) begin
            @(negedge clk);
            w_clr = 1'b0;
            #1;
            if (w_cbusy) nb++;
            if (w_cdone) nd++;
        end
        checks++;
        if (nb != 32 || nd != 1) begin
            failures++; $display("FAIL wide_clear got busy=%0d done=%0d exp 32/1", nb, nd);
        end
        checks++;
        if (w_rd_a !== 32'h0 || w_rd_b !== 32'h0) begin
            failures++; $display("FAIL wide_post_clear got a=%h b=%h exp 0", w_rd_a, w_rd_b);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_reserve();
        test_zero_reg();
        test_clear();
        test_reset_mid_clear();
        test_wide();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/param_reg_bank.md
PARAM_REG_BANK -- requirements
Module: param_reg_bank

Interface
REQ-001 Parameter DATA_W, default 16, sets the data width of every register and port in bits.
REQ-002 Parameter ADDR_W, default 4, sets the address width; DEPTH = 2**ADDR_W registers.
REQ-003 Parameter ZERO_REG, default 0; when 1, register 0 always reads zero and ignores writes and reservations.
REQ-004 Parameter BYPASS, default 1; when 1, read ports forward same-cycle write data.
REQ-005 clk  input  1  single clock; all state updates on the rising edge.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 write  input  1  write enable for the write port.
REQ-008 wrAddr  input  ADDR_W  write address.
REQ-009 wrData  input  DATA_W  write data.
REQ-010 wr_ready  output  1  high when port writes are accepted.
REQ-011 rdAddrA / rdAddrB  input  ADDR_W  read addresses, ports A and B.
REQ-012 rdDataA / rdDataB  output  DATA_W  read data, ports A and B, combinational.
REQ-013 busyA / busyB  output  1  reservation (pending) bit of the register addressed by rdAddrA / rdAddrB.
REQ-014 rsv  input  1  reserve strobe: marks register rsvAddr as pending.
REQ-015 rsvAddr  input  ADDR_W  reservation address.
REQ-016 clr_req  input  1  single-cycle request to zero the whole bank.
REQ-017 clr_busy  output  1  high while the clear sequence runs.
REQ-018 clr_done  output  1  one-cycle pulse when the clear sequence completes.

Function
REQ-019 The bank SHALL hold DEPTH registers of DATA_W bits and one pending bit per register.
REQ-020 A write SHALL take effect at the rising edge when write=1 and wr_ready=1; when wr_ready=0 the write SHALL be dropped with no other effect.
REQ-021 Reads SHALL be combinational with zero latency: rdDataX = regfile[rdAddrX].
REQ-022 With BYPASS=1, when write=1, wr_ready=1 and wrAddr==rdAddrX, rdDataX SHALL equal wrData in the same cycle; with BYPASS=0 the stored value is returned until the edge.
REQ-023 With ZERO_REG=1, reads of address 0 SHALL return 0, including under bypass, and busy for address 0 SHALL be 0.
REQ-024 An accepted write SHALL clear the pending bit of wrAddr; rsv=1 SHALL set the pending bit of rsvAddr.
REQ-025 When an accepted write and rsv target the same address in the same cycle, the pending bit SHALL end set.
REQ-026 busyX SHALL be the combinational pending bit of rdAddrX; bypass SHALL NOT clear busy before the edge.
REQ-027 FSM states: IDLE, CLEAR, DONE; wr_ready = (state==IDLE).
REQ-028 IDLE -> CLEAR on clr_req=1; at that edge all pending bits SHALL clear and the clear counter SHALL load 0.
REQ-029 In CLEAR, one register per cycle SHALL be written with 0 at the counter address, counter +1; after address DEPTH-1 the FSM SHALL go to DONE.
REQ-030 The clear sequence SHALL occupy exactly DEPTH cycles in CLEAR with clr_busy=1, followed by one DONE cycle with clr_done=1 and clr_busy=0, then return to IDLE.
REQ-031 clr_req in CLEAR or DONE SHALL be ignored; rsv in CLEAR or DONE SHALL be ignored.
REQ-032 An accepted write and clr_req in the same IDLE cycle: the write SHALL complete, then the clear SHALL overwrite it.
REQ-033 During CLEAR, reads SHALL return current contents (already-cleared addresses read 0).
REQ-034 The counter SHALL be ADDR_W bits and SHALL not wrap back into CLEAR.

Reset
REQ-035 rst_n=0 SHALL immediately and asynchronously zero all registers and pending bits, set the FSM to IDLE and the counter to 0.
REQ-036 Reset outputs: wr_ready=1, clr_busy=0, clr_done=0, busyA=busyB=0, rdDataA=rdDataB=0.
REQ-037 Reset asserted mid-clear SHALL abort the sequence with no clr_done pulse.
REQ-038 Operation SHALL resume on the first rising edge after rst_n deasserts.

Verification
REQ-039 write wrAddr=5, wrData=16'hBEEF, rdAddrA=5 -> rdDataA=BEEF in the same cycle (BYPASS=1) and after the edge; with BYPASS=0, old value 0 until the edge.
REQ-040 rsv at address 3, then write 3 -> busyA(rdAddrA=3)=1 after the rsv edge and 0 after the write edge; rsv+write to 3 in the same cycle -> busy stays 1.
REQ-041 ZERO_REG=1, write 0 with 16'h1234 -> rdDataA(addr 0)=0, busyA=0.
REQ-042 Fill all 16 registers, pulse clr_req -> clr_busy=1 for exactly 16 cycles, writes issued during that window are dropped, clr_done pulses once, then all reads return 0 and all busy bits are 0.
REQ-043 Assert rst_n=0 mid-clear at counter 7 -> all outputs are at reset values immediately, no clr_done pulse, and a write accepted on the first cycle after release.
REQ-044 DATA_W=32, ADDR_W=5 -> 32 registers hold 32'hFFFFFFFF, and the clear takes 32 cycles.
